r_piso_tx: RTL and testbench

- Parallel-in/serial-out framed transmitter. It is the read/transmit end of the team's 8-bit load-enable registers.
- Accepts one WIDTH-bit word per valid/ready handshake and captures it internally.
- Shifts the word out on a single line: start bit (0), data LSB first, stop bit (1). Each bit is held for DIV clocks.
- Sits between a register bank and any serial sink, for example an r_sipo_rx receiver or an off-chip pin.

---
 rtl/r_piso_tx_pkg.sv | 15 +
 rtl/r_piso_tx_bit_timer.sv | 28 ++
 rtl/r_piso_tx.sv | 89 ++++++++
 tb/tb_r_piso_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/r_piso_tx_pkg.sv
// Shared encodings for the framed serial link (transmitter and companion receiver).
package r_piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/r_piso_tx_bit_timer.sv
// DIV-cycle modulo counter; o_tick marks the last cycle of each bit period.
module r_piso_tx_bit_timer #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/r_piso_tx.sv
// Framed PISO transmitter: start bit, WIDTH data bits LSB first, stop bit, DIV clocks per bit.
module r_piso_tx
  import r_piso_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q_serial,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_done;
  logic             w_tick;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && load_valid;

  // Timer is held cleared while idle so every frame starts on a fresh bit period.
  r_piso_tx_bit_timer #(.DIV(DIV)) u_bit_timer (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (r_state == IDLE),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = START;
      START:   if (w_tick) w_next = DATA;
      DATA:    if (w_tick && (r_bit_cnt == LAST_BIT)) w_next = STOP;
      STOP:    if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_tick;
      if (w_accept) begin
        r_shift   <= d;
        r_bit_cnt <= '0;
      end else if ((r_state == DATA) && w_tick) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    q_serial = LINE_IDLE;
    case (r_state)
      START:   q_serial = START_BIT;
      DATA:    q_serial = r_shift[0];
      STOP:    q_serial = STOP_BIT;
      default: q_serial = LINE_IDLE;
    endcase
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_r_piso_tx.sv
// Scoreboarded bench for r_piso_tx: DIV=4 and DIV=1 instances checked every cycle.
module tb_r_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1;
  logic       lv0, lv1;
  logic       rdy0, q0, busy0, done0;
  logic       rdy1, q1, busy1, done1;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // entry = {q_serial, busy, load_ready, done}
  logic [3:0] sb0[$];
  logic [3:0] sb1[$];
  localparam logic [3:0] IDLE_EXP = 4'b1010;

  always #5 clk = ~clk;

  r_piso_tx #(.WIDTH(8), .DIV(4)) dut0 (
    .clk(clk), .reset(reset), .d(d0), .load_valid(lv0),
    .load_ready(rdy0), .q_serial(q0), .busy(busy0), .done(done0)
  );

  r_piso_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .d(d1), .load_valid(lv1),
    .load_ready(rdy1), .q_serial(q1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_frame(input bit inst, input logic [7:0] data, input int div);
    logic [3:0] e;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < div; c++) begin
        if (b == 0)      e = 4'b0100;
        else if (b == 9) e = 4'b1100;
        else             e = {data[b-1], 3'b100};
        if (inst) sb1.push_back(e);
        else      sb0.push_back(e);
      end
    end
    if (inst) sb1.push_back(4'b1011);
    else      sb0.push_back(4'b1011);
  endtask

  int cyc = 0;

  task automatic step();
    logic [3:0] e0, e1;
    @(negedge clk);
    cyc++;
    e0 = (sb0.size() != 0) ? sb0.pop_front() : IDLE_EXP;
    e1 = (sb1.size() != 0) ? sb1.pop_front() : IDLE_EXP;
    chk("d4_q_serial",   cyc, q0,    e0[3]);
    chk("d4_busy",       cyc, busy0, e0[2]);
    chk("d4_load_ready", cyc, rdy0,  e0[1]);
    chk("d4_done",       cyc, done0, e0[0]);
    chk("d1_q_serial",   cyc, q1,    e1[3]);
    chk("d1_busy",       cyc, busy1, e1[2]);
    chk("d1_load_ready", cyc, rdy1,  e1[1]);
    chk("d1_done",       cyc, done1, e1[0]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    d0 = 8'h00; d1 = 8'h00; lv0 = 1'b0; lv1 = 1'b0;

    // Reset held 3 cycles, with load_valid high to show reset wins.
    lv0 = 1'b1; d0 = 8'hC3;
    steps(3);
    reset = 1'b0; lv0 = 1'b0;
    steps(3);

    // Single frame 0xA5.
    d0 = 8'hA5; lv0 = 1'b1; push_frame(1'b0, 8'hA5, 4);
    step();
    lv0 = 1'b0; d0 = 8'h00;
    steps(42);

    // Back-to-back 0x00 then 0xFF with load_valid held high.
    d0 = 8'h00; lv0 = 1'b1; push_frame(1'b0, 8'h00, 4);
    step();
    d0 = 8'hFF; push_frame(1'b0, 8'hFF, 4);
    steps(41);
    step();
    lv0 = 1'b0;
    steps(42);

    // Ignore load_valid while busy.
    d0 = 8'hA5; lv0 = 1'b1; push_frame(1'b0, 8'hA5, 4);
    step();
    lv0 = 1'b0; d0 = 8'h11;
    steps(8);
    d0 = 8'h3C; lv0 = 1'b1;
    step();
    lv0 = 1'b0;
    steps(35);

    // Reset mid-frame: discard expectation, line idles at the next edge.
    d0 = 8'hA5; lv0 = 1'b1; push_frame(1'b0, 8'hA5, 4);
    step();
    lv0 = 1'b0;
    steps(19);
    reset = 1'b1; sb0.delete();
    step();
    reset = 1'b0;
    steps(5);
    d0 = 8'h5A; lv0 = 1'b1; push_frame(1'b0, 8'h5A, 4);
    step();
    lv0 = 1'b0;
    steps(44);

    // DIV=1 instance, d=0x01.
    d1 = 8'h01; lv1 = 1'b1; push_frame(1'b1, 8'h01, 1);
    step();
    lv1 = 1'b0;
    steps(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
